// File: rtl/ctr_pkg.sv
// Shared types and limits for the prescaled up/down counter family.
package ctr_pkg;

    typedef enum logic {
        CTR_WRAP = 1'b0,
        CTR_SAT  = 1'b1
    } ctr_mode_e;

    localparam int unsigned CTR_MIN_WIDTH    = 2;
    localparam int unsigned CTR_MAX_WIDTH    = 32;
    localparam int unsigned CTR_MAX_PRESCALE = 256;

endpackage

// File: rtl/ctr_prescaler.sv
// Enable divider: tick fires on every PRESCALE-th enabled cycle; restart zeroes the phase.
module ctr_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic restart,
    output logic tick
);

    generate
        if (PRESCALE <= 1) begin : g_direct
            logic unused_direct;
            assign unused_direct = ^{clk, reset, restart};
            assign tick          = enable;
        end else begin : g_div
            localparam int unsigned PW = $clog2(PRESCALE);
            localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

            logic [PW-1:0] pre_q;
            logic [PW-1:0] pre_d;

            always_comb begin
                pre_d = pre_q;
                if (restart) begin
                    pre_d = '0;
                end else if (enable) begin
                    pre_d = (pre_q == LAST) ? '0 : pre_q + PW'(1);
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    pre_q <= '0;
                end else begin
                    pre_q <= pre_d;
                end
            end

            // Caller masks tick with its own higher-priority controls.
            assign tick = enable & (pre_q == LAST);
        end
    endgenerate

endmodule

// File: rtl/ctr_prescaled_updown.sv
// Parametrised up/down counter with prescaler, runtime terminal value,
// wrap/saturate boundary handling, terminal-count pulse and sticky flags.
module ctr_prescaled_updown
    import ctr_pkg::*;
#(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned PRESCALE = 1,
    parameter int unsigned SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             countEnable,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] loadValue,
    input  logic             up,
    input  logic [WIDTH-1:0] maxValue,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             overflow,
    output logic             underflow
);

    localparam ctr_mode_e MODE = (SATURATE != 0) ? CTR_SAT : CTR_WRAP;

    generate
        if (WIDTH < CTR_MIN_WIDTH || WIDTH > CTR_MAX_WIDTH) begin : g_bad_width
            $error("ctr_prescaled_updown: WIDTH must be within 2..32");
        end
        if (PRESCALE < 1 || PRESCALE > CTR_MAX_PRESCALE) begin : g_bad_prescale
            $error("ctr_prescaled_updown: PRESCALE must be within 1..256");
        end
    endgenerate

    logic             tick;
    logic             step;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             tc_q;
    logic             tc_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             unf_q;
    logic             unf_d;

    ctr_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .enable  (countEnable),
        .restart (clear | load),
        .tick    (tick)
    );

    assign step = tick & ~clear & ~load;

    // Next-state: clear > load > step > hold.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (clear) begin
            count_d = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else if (load) begin
            count_d = loadValue;
        end else if (step) begin
            if (up) begin
                if (count_q >= maxValue) begin
                    count_d = (MODE == CTR_SAT) ? count_q : '0;
                    tc_d    = 1'b1;
                    ovf_d   = 1'b1;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (count_q == '0) begin
                    count_d = (MODE == CTR_SAT) ? '0 : maxValue;
                    tc_d    = 1'b1;
                    unf_d   = 1'b1;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign count     = count_q;
    assign tc        = tc_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_ctr_prescaled_updown.sv
// Self-checking bench: three counter configurations driven in lockstep against a behavioural model.
module tb_ctr_prescaled_updown;

    localparam int unsigned N = 3;
    localparam int unsigned CFG_W [N] = '{16, 16, 8};
    localparam int unsigned CFG_P [N] = '{1, 1, 4};
    localparam int unsigned CFG_S [N] = '{0, 1, 0};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        clr = 1'b0;
    logic        ld = 1'b0;
    logic        up = 1'b1;
    logic [15:0] ld_val = 16'h0;
    logic [15:0] max_val = 16'hFFFF;

    logic [15:0] c_o  [N];
    logic        tc_o [N];
    logic        ov_o [N];
    logic        un_o [N];
    logic [7:0]  c2;

    int unsigned m_cnt [N];
    int unsigned m_pre [N];
    bit          m_tc  [N];
    bit          m_ovf [N];
    bit          m_unf [N];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ctr_prescaled_updown #(.WIDTH(16), .PRESCALE(1), .SATURATE(0)) dut_wrap (
        .clk(clk), .reset(rst), .countEnable(en), .clear(clr), .load(ld),
        .loadValue(ld_val), .up(up), .maxValue(max_val),
        .count(c_o[0]), .tc(tc_o[0]), .overflow(ov_o[0]), .underflow(un_o[0]));

    ctr_prescaled_updown #(.WIDTH(16), .PRESCALE(1), .SATURATE(1)) dut_sat (
        .clk(clk), .reset(rst), .countEnable(en), .clear(clr), .load(ld),
        .loadValue(ld_val), .up(up), .maxValue(max_val),
        .count(c_o[1]), .tc(tc_o[1]), .overflow(ov_o[1]), .underflow(un_o[1]));

    ctr_prescaled_updown #(.WIDTH(8), .PRESCALE(4), .SATURATE(0)) dut_pre (
        .clk(clk), .reset(rst), .countEnable(en), .clear(clr), .load(ld),
        .loadValue(ld_val[7:0]), .up(up), .maxValue(max_val[7:0]),
        .count(c2), .tc(tc_o[2]), .overflow(ov_o[2]), .underflow(un_o[2]));

    assign c_o[2] = {8'h00, c2};

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_cnt[k] = 0; m_pre[k] = 0; m_tc[k] = 0; m_ovf[k] = 0; m_unf[k] = 0;
        end
    endtask

    // Behavioural reference: one clock edge of each configuration.
    task automatic model_edge();
        for (int k = 0; k < N; k++) begin
            int unsigned mask;
            int unsigned mx;
            int unsigned c;
            mask = (32'd1 << CFG_W[k]) - 32'd1;
            mx   = 32'(max_val) & mask;
            c    = m_cnt[k];
            m_tc[k] = 0;
            if (rst) begin
                m_cnt[k] = 0; m_pre[k] = 0; m_ovf[k] = 0; m_unf[k] = 0;
            end else if (clr) begin
                m_cnt[k] = 0; m_pre[k] = 0; m_ovf[k] = 0; m_unf[k] = 0;
            end else if (ld) begin
                m_cnt[k] = 32'(ld_val) & mask;
                m_pre[k] = 0;
            end else if (en) begin
                m_pre[k] = (m_pre[k] + 1) % CFG_P[k];
                if (m_pre[k] == 0) begin
                    if (up) begin
                        if (c >= mx) begin
                            m_cnt[k] = (CFG_S[k] != 0) ? c : 0;
                            m_tc[k] = 1; m_ovf[k] = 1;
                        end else begin
                            m_cnt[k] = c + 1;
                        end
                    end else begin
                        if (c == 0) begin
                            m_cnt[k] = (CFG_S[k] != 0) ? 0 : mx;
                            m_tc[k] = 1; m_unf[k] = 1;
                        end else begin
                            m_cnt[k] = c - 1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic clk_step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        #1;
        model_reset();
        for (int k = 0; k < N; k++) begin
            total++;
            if ({c_o[k], tc_o[k], ov_o[k], un_o[k]} !== 19'h0) begin
                bad++;
                $display("FAIL reset_state k=%0d got=%h exp=0", k, {c_o[k], tc_o[k], ov_o[k], un_o[k]});
            end
        end
        clk_step();
        clk_step();
        rst = 1'b0;
    endtask

    task automatic test_count_up();
        en = 1'b1; up = 1'b1; max_val = 16'hFFFF;
        for (int i = 0; i < 20; i++) begin
            clk_step();
            total++;
            if (c_o[0] !== 16'(i + 1) || tc_o[0] !== 1'b0 || ov_o[0] !== 1'b0 || un_o[0] !== 1'b0) begin
                bad++;
                $display("FAIL count_up i=%0d got=%h/%b%b%b exp=%h/000", i, c_o[0], tc_o[0], ov_o[0], un_o[0], 16'(i + 1));
            end
            for (int k = 0; k < N; k++) begin
                total++;
                if ({c_o[k], tc_o[k], ov_o[k], un_o[k]} !== {16'(m_cnt[k]), m_tc[k], m_ovf[k], m_unf[k]}) begin
                    bad++;
                    $display("FAIL count_up_model k=%0d got=%h exp=%h", k, {c_o[k], tc_o[k], ov_o[k], un_o[k]},
                             {16'(m_cnt[k]), m_tc[k], m_ovf[k], m_unf[k]});
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_c [7] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd0, 16'd1};
        en = 1'b0; clr = 1'b1;
        clk_step();
        clr = 1'b0; en = 1'b1; up = 1'b1; max_val = 16'd5;
        for (int i = 0; i < 7; i++) begin
            clk_step();
            total++;
            if (c_o[0] !== exp_c[i] || tc_o[0] !== (i == 5) || ov_o[0] !== (i >= 5)) begin
                bad++;
                $display("FAIL wrap i=%0d got=%h tc=%b ov=%b exp=%h tc=%b ov=%b", i, c_o[0], tc_o[0], ov_o[0],
                         exp_c[i], (i == 5), (i >= 5));
            end
            for (int k = 0; k < N; k++) begin
                total++;
                if ({c_o[k], tc_o[k], ov_o[k], un_o[k]} !== {16'(m_cnt[k]), m_tc[k], m_ovf[k], m_unf[k]}) begin
                    bad++;
                    $display("FAIL wrap_model k=%0d got=%h exp=%h", k, {c_o[k], tc_o[k], ov_o[k], un_o[k]},
                             {16'(m_cnt[k]), m_tc[k], m_ovf[k], m_unf[k]});
                end
            end
        end
    endtask

    task automatic test_saturate_down();
        logic [15:0] exp_c [4] = '{16'd1, 16'd0, 16'd0, 16'd0};
        en = 1'b0; clr = 1'b1;
        clk_step();
        clr = 1'b0; ld = 1'b1; ld_val = 16'd2; up = 1'b0; max_val = 16'hFFFF;
        clk_step();
        ld = 1'b0; en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            clk_step();
            total++;
            if (c_o[1] !== exp_c[i] || tc_o[1] !== (i >= 2) || un_o[1] !== (i >= 2)) begin
                bad++;
                $display("FAIL sat_down i=%0d got=%h tc=%b un=%b exp=%h tc=%b un=%b", i, c_o[1], tc_o[1], un_o[1],
                         exp_c[i], (i >= 2), (i >= 2));
            end
            for (int k = 0; k < N; k++) begin
                total++;
                if ({c_o[k], tc_o[k], ov_o[k], un_o[k]} !== {16'(m_cnt[k]), m_tc[k], m_ovf[k], m_unf[k]}) begin
                    bad++;
                    $display("FAIL sat_model k=%0d got=%h exp=%h", k, {c_o[k], tc_o[k], ov_o[k], un_o[k]},
                             {16'(m_cnt[k]), m_tc[k], m_ovf[k], m_unf[k]});
                end
            end
        end
    endtask

    task automatic test_prescale();
        logic       en_pat [12] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 1, 1, 1};
        logic [7:0] exp_c  [12] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 2, 2};
        en = 1'b0; clr = 1'b1;
        clk_step();
        clr = 1'b0; up = 1'b1; max_val = 16'hFFFF;
        for (int i = 0; i < 12; i++) begin
            en = en_pat[i];
            clk_step();
            total++;
            if (c2 !== exp_c[i]) begin
                bad++;
                $display("FAIL prescale edge=%0d got=%h exp=%h", i + 1, c2, exp_c[i]);
            end
            for (int k = 0; k < N; k++) begin
                total++;
                if ({c_o[k], tc_o[k], ov_o[k], un_o[k]} !== {16'(m_cnt[k]), m_tc[k], m_ovf[k], m_unf[k]}) begin
                    bad++;
                    $display("FAIL prescale_model k=%0d got=%h exp=%h", k, {c_o[k], tc_o[k], ov_o[k], un_o[k]},
                             {16'(m_cnt[k]), m_tc[k], m_ovf[k], m_unf[k]});
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        max_val = 16'd3; up = 1'b1; en = 1'b1;
        for (int i = 0; i < 5; i++) clk_step();
        clr = 1'b1; ld = 1'b1; ld_val = 16'h5555;
        clk_step();
        for (int k = 0; k < N; k++) begin
            total++;
            if ({c_o[k], tc_o[k], ov_o[k], un_o[k]} !== 19'h0) begin
                bad++;
                $display("FAIL clr_ld_step k=%0d got=%h exp=0", k, {c_o[k], tc_o[k], ov_o[k], un_o[k]});
            end
        end
        clr = 1'b0; ld_val = 16'h1234; max_val = 16'hFFFF;
        clk_step();
        total++;
        if (c_o[0] !== 16'h1234 || c2 !== 8'h34 || tc_o[0] !== 1'b0) begin
            bad++;
            $display("FAIL load_step got=%h/%h tc=%b exp=1234/34 tc=0", c_o[0], c2, tc_o[0]);
        end
        ld = 1'b0;
        clk_step();
        for (int k = 0; k < N; k++) begin
            total++;
            if ({c_o[k], tc_o[k], ov_o[k], un_o[k]} !== {16'(m_cnt[k]), m_tc[k], m_ovf[k], m_unf[k]}) begin
                bad++;
                $display("FAIL after_load_model k=%0d got=%h exp=%h", k, {c_o[k], tc_o[k], ov_o[k], un_o[k]},
                         {16'(m_cnt[k]), m_tc[k], m_ovf[k], m_unf[k]});
            end
        end
    endtask

    task automatic test_async_reset();
        en = 1'b0; up = 1'b1; max_val = 16'hFFFF; ld = 1'b1; ld_val = 16'hFFFF;
        clk_step();
        ld = 1'b0; en = 1'b1;
        clk_step();
        ld = 1'b1; ld_val = 16'h009F;
        clk_step();
        ld = 1'b0;
        clk_step();
        total++;
        if (c_o[0] !== 16'h00A0 || ov_o[0] !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset got=%h ov=%b exp=00a0 ov=1", c_o[0], ov_o[0]);
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        for (int k = 0; k < N; k++) begin
            total++;
            if ({c_o[k], tc_o[k], ov_o[k], un_o[k]} !== 19'h0) begin
                bad++;
                $display("FAIL async_reset k=%0d got=%h exp=0", k, {c_o[k], tc_o[k], ov_o[k], un_o[k]});
            end
        end
        clk_step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            clk_step();
            total++;
            if (c_o[0] !== 16'(i + 1)) begin
                bad++;
                $display("FAIL resume i=%0d got=%h exp=%h", i, c_o[0], 16'(i + 1));
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            en  = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 40) == 0);
            ld  = ($urandom_range(0, 15) == 0);
            up  = ($urandom_range(0, 1) != 0);
            ld_val = 16'($urandom);
            if ($urandom_range(0, 49) == 0) begin
                case ($urandom_range(0, 2))
                    0:       max_val = 16'($urandom_range(0, 20));
                    1:       max_val = 16'hFFFF;
                    default: max_val = 16'($urandom);
                endcase
            end
            clk_step();
            for (int k = 0; k < N; k++) begin
                total++;
                if ({c_o[k], tc_o[k], ov_o[k], un_o[k]} !== {16'(m_cnt[k]), m_tc[k], m_ovf[k], m_unf[k]}) begin
                    bad++;
                    $display("FAIL random cyc=%0d k=%0d got=%h exp=%h", i, k, {c_o[k], tc_o[k], ov_o[k], un_o[k]},
                             {16'(m_cnt[k]), m_tc[k], m_ovf[k], m_unf[k]});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_wrap();
        test_saturate_down();
        test_prescale();
        test_simultaneous();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
